// File: rtl/dev_tx_cmd_split.sv
// dev_tx_cmd_split: pops one DMA command from the device TX command FIFO.
// It splits the command into memory requests that are at most
// P_MAX_PAYLOAD_DW long and never cross a 1024-DW (4 KB) boundary.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for a command; pops the FIFO front when present
//   S_CALC | sizing the next chunk from address, remainder and max size
//   S_REQ  | presenting the request; holds until accepted
module dev_tx_cmd_split #(
  parameter int P_FIFO_DATA_WIDTH = 30,
  parameter int P_MAX_PAYLOAD_DW  = 32
) (
  input  logic                         pcie_user_clk,
  input  logic                         pcie_user_rst,
  input  logic                         cmd_fifo_empty_n,
  input  logic [P_FIFO_DATA_WIDTH-1:0] cmd_fifo_rd_data,
  output logic                         cmd_fifo_rd_en,
  output logic                         tx_req_valid,
  input  logic                         tx_req_ready,
  output logic [19:0]                  tx_req_addr,
  output logic [9:0]                   tx_req_len,
  output logic                         tx_req_last,
  output logic                         tx_cmd_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_REQ  = 2'd2
  } state_t;

  localparam logic [10:0] C_MAX_DW = 11'(P_MAX_PAYLOAD_DW);

  state_t      state;
  state_t      state_nxt;
  logic [19:0] r_addr;
  logic [10:0] r_rem;
  logic [10:0] r_chunk;
  logic [10:0] w_bound;
  logic [10:0] w_chunk;
  logic [10:0] w_cmd_len;
  logic        w_last;
  logic        w_fire;

  // Command length field 0 stands for a full 1024-DW transfer.
  assign w_cmd_len = (cmd_fifo_rd_data[29:20] == 10'd0) ? 11'd1024
                                                         : {1'b0, cmd_fifo_rd_data[29:20]};
  assign w_last    = (r_chunk == r_rem);
  assign w_fire    = (state == S_REQ) && tx_req_ready;

  // Chunk = min(remaining, max payload, DWs left before the next 4 KB line).
  always_comb begin
    w_bound = 11'd1024 - {1'b0, r_addr[9:0]};
    w_chunk = r_rem;
    if (C_MAX_DW < w_chunk) w_chunk = C_MAX_DW;
    if (w_bound < w_chunk)  w_chunk = w_bound;
  end

  // State register.
  always_ff @(posedge pcie_user_clk or posedge pcie_user_rst) begin
    if (pcie_user_rst) state <= S_IDLE;
    else               state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_fifo_empty_n) state_nxt = S_CALC;
      S_CALC:  state_nxt = S_REQ;
      S_REQ:   if (tx_req_ready) state_nxt = w_last ? S_IDLE : S_CALC;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs; the pop strobe is also masked by reset so nothing is read while held.
  always_comb begin
    cmd_fifo_rd_en = (state == S_IDLE) && cmd_fifo_empty_n && !pcie_user_rst;
    tx_req_valid   = (state == S_REQ);
    tx_req_addr    = r_addr;
    tx_req_len     = r_chunk[9:0];
    tx_req_last    = (state == S_REQ) && w_last;
  end

  // Address / remainder / chunk datapath; address wraps modulo 2^20.
  always_ff @(posedge pcie_user_clk or posedge pcie_user_rst) begin
    if (pcie_user_rst) begin
      r_addr  <= 20'd0;
      r_rem   <= 11'd0;
      r_chunk <= 11'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_fifo_empty_n) begin
            r_addr <= cmd_fifo_rd_data[19:0];
            r_rem  <= w_cmd_len;
          end
        end
        S_CALC: r_chunk <= w_chunk;
        S_REQ: begin
          if (tx_req_ready && !w_last) begin
            r_addr <= r_addr + {9'd0, r_chunk};
            r_rem  <= r_rem - r_chunk;
          end
        end
        default: ;
      endcase
    end
  end

  // Completion strobe, one cycle after the last request is accepted.
  always_ff @(posedge pcie_user_clk or posedge pcie_user_rst) begin
    if (pcie_user_rst) tx_cmd_done <= 1'b0;
    else               tx_cmd_done <= w_fire && w_last;
  end

endmodule

// File: tb/tb_dev_tx_cmd_split.sv
// Testbench for dev_tx_cmd_split: FIFO model, request scoreboard, vector table.
module tb_dev_tx_cmd_split;

  logic        pcie_user_clk = 1'b0;
  logic        pcie_user_rst = 1'b1;
  logic        cmd_fifo_empty_n = 1'b0;
  logic [29:0] cmd_fifo_rd_data = '0;
  logic        cmd_fifo_rd_en;
  logic        tx_req_valid;
  logic        tx_req_ready = 1'b1;
  logic [19:0] tx_req_addr;
  logic [9:0]  tx_req_len;
  logic        tx_req_last;
  logic        tx_cmd_done;

  dev_tx_cmd_split #(.P_FIFO_DATA_WIDTH(30), .P_MAX_PAYLOAD_DW(32)) dut (
    .pcie_user_clk    (pcie_user_clk),
    .pcie_user_rst    (pcie_user_rst),
    .cmd_fifo_empty_n (cmd_fifo_empty_n),
    .cmd_fifo_rd_data (cmd_fifo_rd_data),
    .cmd_fifo_rd_en   (cmd_fifo_rd_en),
    .tx_req_valid     (tx_req_valid),
    .tx_req_ready     (tx_req_ready),
    .tx_req_addr      (tx_req_addr),
    .tx_req_len       (tx_req_len),
    .tx_req_last      (tx_req_last),
    .tx_cmd_done      (tx_cmd_done)
  );

  always #5 pcie_user_clk = ~pcie_user_clk;

  typedef struct {
    logic [9:0]       len_f;
    logic [19:0]      addr;
    int               n_req;
    logic [3:0][19:0] e_addr;
    logic [3:0][9:0]  e_len;
  } vec_t;

  typedef struct packed {
    logic [19:0] a;
    logic [9:0]  l;
    logic        last;
  } req_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done   = 0;
  int          n_acc    = 0;
  int          pops     = 0;
  int          cmds     = 0;
  int          cyc      = 0;
  int          pop_cyc  = 0;
  logic        pop_pend = 1'b0;
  logic        rand_rdy = 1'b0;
  logic [29:0] fifo_q[$];
  req_t        sb_q[$];
  vec_t        vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [9:0] lf, input logic [19:0] a, input int n,
                              input logic [19:0] a0, input logic [19:0] a1,
                              input logic [19:0] a2, input logic [19:0] a3,
                              input logic [9:0] l0, input logic [9:0] l1,
                              input logic [9:0] l2, input logic [9:0] l3);
    vec_t v;
    v.len_f = lf; v.addr = a; v.n_req = n;
    v.e_addr[0] = a0; v.e_addr[1] = a1; v.e_addr[2] = a2; v.e_addr[3] = a3;
    v.e_len[0] = l0;  v.e_len[1] = l1;  v.e_len[2] = l2;  v.e_len[3] = l3;
    return v;
  endfunction

  task automatic fifo_drive();
    cmd_fifo_empty_n = (fifo_q.size() != 0);
    cmd_fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 30'd0;
  endtask

  // Queue a command and its expected requests. More than four requests means
  // a uniform run: e_addr[0] stepping by e_len[0].
  task automatic push_vec(input vec_t v);
    req_t r;
    @(posedge pcie_user_clk); #2;
    fifo_q.push_back({v.len_f, v.addr});
    fifo_drive();
    cmds++;
    for (int i = 0; i < v.n_req; i++) begin
      if (v.n_req > 4) begin
        r.a = 20'(v.e_addr[0] + 20'(i) * 20'(v.e_len[0]));
        r.l = v.e_len[0];
      end else begin
        r.a = v.e_addr[i];
        r.l = v.e_len[i];
      end
      r.last = (i == v.n_req - 1);
      sb_q.push_back(r);
    end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while ((sb_q.size() != 0 || fifo_q.size() != 0 || tx_req_valid) && k < budget) begin
      @(negedge pcie_user_clk);
      k++;
    end
    chk({nm, "_timeout"}, 32'(k >= budget), 32'd0);
    repeat (2) @(negedge pcie_user_clk);
  endtask

  task automatic wait_valid(input int budget, input string nm);
    int k = 0;
    while (!tx_req_valid && k < budget) begin
      @(negedge pcie_user_clk);
      k++;
    end
    chk({nm, "_valid_timeout"}, 32'(k >= budget), 32'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rd_en"}, 32'(cmd_fifo_rd_en), 32'd0);
    chk({nm, "_valid"}, 32'(tx_req_valid), 32'd0);
    chk({nm, "_addr"},  32'(tx_req_addr),  32'd0);
    chk({nm, "_len"},   32'(tx_req_len),   32'd0);
    chk({nm, "_last"},  32'(tx_req_last),  32'd0);
    chk({nm, "_done"},  32'(tx_cmd_done),  32'd0);
  endtask

  // FIFO model: pop the front entry just after an edge where rd_en was high.
  always @(posedge pcie_user_clk) begin
    #1;
    if (pop_pend) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pops++;
      pop_pend = 1'b0;
    end
    fifo_drive();
  end

  always @(posedge pcie_user_clk) begin
    #1;
    if (rand_rdy) tx_req_ready = ($urandom_range(0, 1) == 1);
  end

  // Monitor on the falling edge: scoreboard, stability, done timing, pop rules.
  logic        done_due = 1'b0;
  logic        prev_rd = 1'b0;
  logic        prev_stall = 1'b0;
  logic        lat_armed = 1'b0;
  logic [19:0] s_addr;
  logic [9:0]  s_len;
  logic        s_last;
  always @(negedge pcie_user_clk) begin
    req_t e;
    cyc++;
    if (pcie_user_rst) begin
      done_due = 1'b0; prev_rd = 1'b0; prev_stall = 1'b0; lat_armed = 1'b0;
    end else begin
      chk("done_pulse", 32'(tx_cmd_done), 32'(done_due));
      if (tx_cmd_done) n_done++;
      done_due = 1'b0;
      chk("rd_en_single", 32'(prev_rd && cmd_fifo_rd_en), 32'd0);
      chk("rd_en_while_valid", 32'(cmd_fifo_rd_en && tx_req_valid), 32'd0);
      if (lat_armed && tx_req_valid) begin
        chk("first_req_latency", 32'(cyc - pop_cyc), 32'd2);
        lat_armed = 1'b0;
      end
      if (cmd_fifo_rd_en) begin
        pop_pend = 1'b1; pop_cyc = cyc; lat_armed = 1'b1;
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(tx_req_valid), 32'd1);
        chk("stall_addr",  32'(tx_req_addr),  32'(s_addr));
        chk("stall_len",   32'(tx_req_len),   32'(s_len));
        chk("stall_last",  32'(tx_req_last),  32'(s_last));
      end
      if (tx_req_valid && tx_req_ready) begin
        n_acc++;
        if (sb_q.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("req_addr", 32'(tx_req_addr), 32'(e.a));
          chk("req_len",  32'(tx_req_len),  32'(e.l));
          chk("req_last", 32'(tx_req_last), 32'(e.last));
        end
        if (tx_req_last) done_due = 1'b1;
      end
      prev_rd    = cmd_fifo_rd_en;
      prev_stall = tx_req_valid && !tx_req_ready;
      s_addr = tx_req_addr; s_len = tx_req_len; s_last = tx_req_last;
    end
  end

  initial begin
    int p0;
    int a0;
    vecs[0] = mk(10'd8,   20'h00010, 1,  20'h00010, 20'h0, 20'h0, 20'h0, 10'd8, 10'd0, 10'd0, 10'd0);
    vecs[1] = mk(10'd100, 20'h00000, 4,  20'h00000, 20'h00020, 20'h00040, 20'h00060,
                 10'd32, 10'd32, 10'd32, 10'd4);
    vecs[2] = mk(10'd16,  20'h003F8, 2,  20'h003F8, 20'h00400, 20'h0, 20'h0, 10'd8, 10'd8, 10'd0, 10'd0);
    vecs[3] = mk(10'd0,   20'h00400, 32, 20'h00400, 20'h0, 20'h0, 20'h0, 10'd32, 10'd0, 10'd0, 10'd0);
    vecs[4] = mk(10'd32,  20'hFFFF0, 2,  20'hFFFF0, 20'h00000, 20'h0, 20'h0, 10'd16, 10'd16, 10'd0, 10'd0);
    vecs[5] = mk(10'd1,   20'h003FF, 1,  20'h003FF, 20'h0, 20'h0, 20'h0, 10'd1, 10'd0, 10'd0, 10'd0);
    vecs[6] = mk(10'd40,  20'h003F0, 2,  20'h003F0, 20'h00400, 20'h0, 20'h0, 10'd16, 10'd24, 10'd0, 10'd0);

    repeat (3) @(posedge pcie_user_clk);
    #1 chk_zero("reset");
    @(posedge pcie_user_clk); #2 pcie_user_rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      push_vec(vecs[i]);
      wait_idle(200, $sformatf("vec%0d", i));
    end

    // Back-to-back commands: next pop lands in the done cycle.
    push_vec(vecs[0]);
    push_vec(vecs[2]);
    push_vec(vecs[4]);
    wait_idle(200, "b2b");

    // Backpressure on the second request of the 100-DW split.
    @(posedge pcie_user_clk); #2 tx_req_ready = 1'b0;
    push_vec(vecs[1]);
    push_vec(vecs[0]);
    wait_valid(50, "bp_req1");
    @(posedge pcie_user_clk); #2 tx_req_ready = 1'b1;
    @(posedge pcie_user_clk); #2 tx_req_ready = 1'b0;
    wait_valid(50, "bp_req2");
    p0 = pops;
    repeat (5) @(posedge pcie_user_clk);
    #2 chk("bp_no_pop", 32'(pops), 32'(p0));
    chk("bp_valid_held", 32'(tx_req_valid), 32'd1);
    tx_req_ready = 1'b1;
    wait_idle(200, "bp");

    // Random backpressure.
    rand_rdy = 1'b1;
    push_vec(vecs[1]);
    push_vec(vecs[3]);
    push_vec(vecs[6]);
    wait_idle(2000, "rand");
    @(posedge pcie_user_clk); #2 rand_rdy = 1'b0; tx_req_ready = 1'b1;

    // Reset after the first request of the 100-DW split.
    a0 = n_acc;
    push_vec(vecs[1]);
    begin
      int k = 0;
      while (n_acc == a0 && k < 50) begin @(negedge pcie_user_clk); k++; end
      chk("rst_first_acc_timeout", 32'(k >= 50), 32'd0);
    end
    @(posedge pcie_user_clk); #2 pcie_user_rst = 1'b1;
    #1 chk_zero("rst_mid");
    sb_q.delete();
    push_vec(mk(10'd4, 20'h00100, 1, 20'h00100, 20'h0, 20'h0, 20'h0, 10'd4, 10'd0, 10'd0, 10'd0));
    repeat (3) @(posedge pcie_user_clk);
    #1 chk("rst_hold_rd_en", 32'(cmd_fifo_rd_en), 32'd0);
    chk("rst_hold_fifo", 32'(fifo_q.size()), 32'd1);
    #1 pcie_user_rst = 1'b0;
    wait_idle(200, "rst_new");

    chk("total_pops", 32'(pops), 32'(cmds));
    chk("total_done", 32'(n_done), 32'(cmds - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
